// File: rtl/fib_pkg.sv
// Shared Fibonacci definitions: term table, sizing constants and monitor state encoding.
// The upstream step counter can reuse fib_value() so both ends agree on the sequence.
package fib_pkg;

  localparam int FIB_MAX_TERMS = 10;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } mon_state_t;

  // F(0)..F(9); anything beyond the table decodes to zero.
  function automatic logic [7:0] fib_value(input logic [3:0] index);
    logic [7:0] value;
    case (index)
      4'd0:    value = 8'd0;
      4'd1:    value = 8'd1;
      4'd2:    value = 8'd1;
      4'd3:    value = 8'd2;
      4'd4:    value = 8'd3;
      4'd5:    value = 8'd5;
      4'd6:    value = 8'd8;
      4'd7:    value = 8'd13;
      4'd8:    value = 8'd21;
      4'd9:    value = 8'd34;
      default: value = 8'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/fib_term_rom.sv
// Pure combinational index -> Fibonacci term decode, truncated to DW bits.
// Indices at or beyond N_TERMS return zero.
module fib_term_rom
  import fib_pkg::*;
#(
  parameter int DW      = 6,
  parameter int N_TERMS = 10
) (
  input  logic [3:0]    index,
  output logic [DW-1:0] value
);

  logic [DW-1:0] rom_table [0:15];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rom
      if (gi < N_TERMS && gi < FIB_MAX_TERMS) begin : g_term
        assign rom_table[gi] = DW'(fib_value(4'(gi)));
      end else begin : g_zero
        assign rom_table[gi] = '0;
      end
    end
  endgenerate

  assign value = rom_table[index];

endmodule

// File: rtl/fib_sequence_monitor.sv
// Receive-side checker for a strobed Fibonacci term stream: locks on F(0),
// tracks the index, and reports match/err/wrap pulses plus a saturating error count.
module fib_sequence_monitor
  import fib_pkg::*;
#(
  parameter int DW      = 6,
  parameter int N_TERMS = 10,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  output logic [3:0]       idx,
  output logic [DW-1:0]    expected,
  output logic             locked,
  output logic             match,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] LAST_IDX = 4'(N_TERMS - 1);

  mon_state_t       state_reg, state_next;
  logic [3:0]       idx_reg, idx_next;
  logic [ERR_W-1:0] count_reg, count_next;
  logic             match_reg, match_next;
  logic             err_reg, err_next;
  logic             wrap_reg, wrap_next;
  logic [3:0]       next_idx;

  assign next_idx = (idx_reg == LAST_IDX) ? 4'd0 : idx_reg + 4'd1;

  fib_term_rom #(
    .DW      (DW),
    .N_TERMS (N_TERMS)
  ) u_rom (
    .index (next_idx),
    .value (expected)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= UNLOCKED;
      idx_reg   <= '0;
      count_reg <= '0;
      match_reg <= 1'b0;
      err_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
      match_reg <= match_next;
      err_reg   <= err_next;
      wrap_reg  <= wrap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    match_next = 1'b0;
    err_next   = 1'b0;
    wrap_next  = 1'b0;
    if (din_valid) begin
      case (state_reg)
        UNLOCKED: begin
          // Hunt silently for F(0); non-zero terms are not errors yet.
          if (din == '0) begin
            state_next = LOCKED;
            idx_next   = '0;
            match_next = 1'b1;
          end
        end
        LOCKED: begin
          if (din == expected) begin
            idx_next   = next_idx;
            match_next = 1'b1;
            wrap_next  = (idx_reg == LAST_IDX);
          end else begin
            err_next   = 1'b1;
            count_next = (&count_reg) ? count_reg : count_reg + ERR_W'(1);
            idx_next   = '0;
            // A stray zero is taken as a restart of the sequence.
            if (din != '0) state_next = UNLOCKED;
          end
        end
        default: begin
          state_next = UNLOCKED;
          idx_next   = '0;
        end
      endcase
    end
  end

  assign idx       = idx_reg;
  assign locked    = (state_reg == LOCKED);
  assign match     = match_reg;
  assign err       = err_reg;
  assign wrap      = wrap_reg;
  assign err_count = count_reg;

endmodule

// File: doc/fib_sequence_monitor.md
Name: fib_sequence_monitor

Overview:
- Receive-side checker for the Fibonacci step counter's 6-bit output stream.
- Each strobed term is compared against the expected next Fibonacci value, and the monitor reports the recovered index, lock status, per-beat match/error/wrap pulses and a saturating error count.
- Sits downstream of the counter on the same clock, feeding LEDs/7-seg or a self-check in lab benches.

Parameters:
- DW, 6, data width of a term; must satisfy F(N_TERMS-1) < 2^DW.
- N_TERMS, 10, sequence length before wrap (terms F(0)..F(N_TERMS-1) = 0,1,1,2,3,5,8,13,21,34); range 3..10 with DW=6.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  DW  Fibonacci term presented by the upstream counter.
- din_valid  in  1  one-cycle strobe: din holds a new term this cycle.
- idx  out  4  index of the last accepted term (0..N_TERMS-1).
- expected  out  DW  value F(next idx), where next idx = 0 if idx==N_TERMS-1, else idx+1; combinational decode of idx.
- locked  out  1  monitor is synchronised to the stream.
- match  out  1  one-cycle pulse: accepted term equalled expected.
- err  out  1  one-cycle pulse: term mismatched while locked.
- wrap  out  1  one-cycle pulse: accepted F(0) after index N_TERMS-1.
- err_count  out  ERR_W  saturating count of err pulses.

Behaviour:
- Reset (async, immediate): state UNLOCKED, idx=0, locked=0, match=err=wrap=0, err_count=0. Reset asserted mid-stream discards all history.
- All outputs except `expected` are registered; pulses appear the cycle after the din_valid beat (1-cycle latency) and last exactly one cycle.
- din_valid=0: state, idx and err_count hold; match/err/wrap are 0. din is ignored.
- State UNLOCKED (hunting):
  - valid & din==0 -> LOCKED, idx=0, match=1.
  - valid & din!=0 -> stay UNLOCKED. No err pulse and no count while hunting.
- State LOCKED, on a valid beat:
  - din==expected -> idx advances (N_TERMS-1 wraps to 0), match=1. wrap=1 iff the previous idx was N_TERMS-1.
  - din!=expected -> err=1 and err_count+1 (holds at all-ones).
    - If din==0: stay LOCKED, idx=0 (immediate resync). No match pulse on this beat.
    - Else: -> UNLOCKED, idx=0, locked=0.
- Duplicate values are handled purely by the strobe. The value 1 at idx 1 and idx 2 is two distinct beats; a held din without din_valid is never counted.
- `locked` is 1 exactly when state is LOCKED.
- Widths: the compare is full DW bits. `expected` for idx outside 0..N_TERMS-1 (unreachable) decodes to 0.

Decomposition:
- Shared package fib_pkg:
  - FIB_MAX_TERMS=10.
  - fib_value(index) function/ROM constant covering F(0)..F(9).
  - State enum {UNLOCKED, LOCKED}.
  - The existing counter can later reuse the same table.
- One natural sub-module, fib_term_rom: pure index->value decode used for `expected`.
- The FSM and counters stay in the top.

Test Plan:
- Reset, then idle with no din_valid -> idx=0, locked=0, err_count=0, all pulses 0. Assert reset mid-stream -> the same values appear immediately.
- Valid beats 0,1,1,2,3,5,8,13,21,34 -> lock on 0; match pulses on 10 beats; idx=9, expected=0. Next beat 0 -> match=1, wrap=1, idx=0.
- Same stream with 3 idle cycles between beats, and din held constant during the gaps -> identical idx progression; no extra match or err pulses.
- Locked at idx=3 (term 2 accepted), send 4 -> err=1, err_count=1, locked=0. Send 5 -> no err, count stays 1. Send 0 -> locked=1, idx=0, match=1.
- Locked at idx=5 (term 5 accepted), send 0 -> err=1, count+1, locked stays 1, idx=0. Send 1 -> match=1, idx=1.
- ERR_W=2: force 5 mismatches, relocking with 0 between them -> err_count reads 1,2,3,3,3 (saturates at 3); err pulses fire on all 5.
